// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: load/store encodings, FSM states, widths.
package mem_stage_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CNT_W      = 3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [DATA_W-1:0]     ZeroWord = '0;
  localparam logic [REG_ADDR_W-1:0] NOPAddr  = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } state_e;

  // Number of bytes moved by an access of the given width encoding.
  function automatic logic [CNT_W-1:0] byte_count(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic load_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/mem_stage_ext.sv
// Load result extension: sign- or zero-extends the assembled little-endian bytes.
module mem_ext
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic [2:0]            funct3,
  input  logic [WORD_W-1:0]     raw,
  output logic [DATA_WIDTH-1:0] ext_data_c
);

  // Select width and extension mode from funct3.
  always_comb begin
    ext_data_c = '0;
    case (funct3)
      F3_B:    ext_data_c = {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]};
      F3_H:    ext_data_c = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
      F3_BU:   ext_data_c = DATA_WIDTH'(raw[7:0]);
      F3_HU:   ext_data_c = DATA_WIDTH'(raw[15:0]);
      default: ext_data_c = DATA_WIDTH'(raw);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB register; byte-serial loads/stores over an 8-bit RAM port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_W,
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wd,
  input  logic                      ex_wreg,
  input  logic [DATA_WIDTH-1:0]     ex_wdata,
  input  logic                      ex_mem_rd,
  input  logic                      ex_mem_wr,
  input  logic [2:0]                ex_funct3,
  input  logic [ADDR_WIDTH-1:0]     ex_mem_addr,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [7:0]                mem_din,
  output logic [ADDR_WIDTH-1:0]     mem_a,
  output logic [7:0]                mem_dout,
  output logic                      mem_wr,
  output logic                      stall_req,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0]     wb_wdata
);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          n_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [2:0]                f3_q;
  logic [REG_ADDR_WIDTH-1:0] wd_q;
  logic                      wreg_q;
  logic [WORD_W-1:0]         sdata_q;
  logic [WORD_W-1:0]         asm_q, asm_d;
  logic [1:0]                cap_idx;
  logic                      accept;
  logic                      wb_we_d;
  logic [REG_ADDR_WIDTH-1:0] wb_waddr_d;
  logic [DATA_WIDTH-1:0]     wb_wdata_d;
  logic [DATA_WIDTH-1:0]     load_data_c;

  assign n_q     = byte_count(f3_q);
  assign cap_idx = 2'(cnt_q - 3'd1);

  mem_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .funct3     (f3_q),
    .raw        (asm_d),
    .ext_data_c (load_data_c)
  );

  // Byte assembly: the byte read last cycle lands in slot cnt-1; cleared while idle.
  always_comb begin
    asm_d = asm_q;
    if (state_q == ST_IDLE) begin
      asm_d = '0;
    end else if (state_q == ST_LOAD) begin
      asm_d[{cap_idx, 3'b000} +: 8] = mem_din;
    end
  end

  // Next state, RAM port, stall and write-back selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    mem_a      = addr_q + ADDR_WIDTH'(cnt_q);
    mem_dout   = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
    mem_wr     = 1'b0;
    stall_req  = 1'b0;
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr;
    wb_wdata_d = wb_wdata;

    case (state_q)
      ST_IDLE: begin
        mem_a    = ex_mem_addr;
        mem_dout = ex_store_data[7:0];
        if (ex_valid) begin
          accept = 1'b1;
          cnt_d  = 3'd1;
          if (ex_mem_rd) begin
            if (load_legal(ex_funct3)) begin
              state_d   = ST_LOAD;
              stall_req = 1'b1;
            end
          end else if (ex_mem_wr) begin
            if (store_legal(ex_funct3)) begin
              mem_wr = 1'b1;
              if (byte_count(ex_funct3) > 3'd1) begin
                state_d   = ST_STORE;
                stall_req = 1'b1;
              end
            end
          end else if (ex_wreg && (ex_wd != REG_ADDR_WIDTH'(NOPAddr))) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = ex_wd;
            wb_wdata_d = ex_wdata;
          end
        end
      end

      ST_LOAD: begin
        if (cnt_q == n_q) begin
          state_d = ST_IDLE;
          if (wreg_q && (wd_q != REG_ADDR_WIDTH'(NOPAddr))) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = wd_q;
            wb_wdata_d = load_data_c;
          end
        end else begin
          stall_req = 1'b1;
          cnt_d     = cnt_q + 3'd1;
        end
      end

      ST_STORE: begin
        mem_wr = 1'b1;
        if (cnt_q == (n_q - 3'd1)) begin
          state_d = ST_IDLE;
        end else begin
          stall_req = 1'b1;
          cnt_d     = cnt_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Reset silences the RAM port at once, even mid-access.
    if (rst) begin
      mem_a     = '0;
      mem_dout  = '0;
      mem_wr    = 1'b0;
      stall_req = 1'b0;
      accept    = 1'b0;
    end
  end

  // FSM state, byte counter and assembly register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  // Operand capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      sdata_q <= '0;
    end else if (accept) begin
      addr_q  <= ex_mem_addr;
      f3_q    <= ex_funct3;
      wd_q    <= ex_wd;
      wreg_q  <= ex_wreg;
      sdata_q <= WORD_W'(ex_store_data);
    end
  end

  // MEM/WB output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= DATA_WIDTH'(ZeroWord);
    end else begin
      wb_we    <= wb_we_d;
      wb_waddr <= wb_waddr_d;
      wb_wdata <= wb_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte RAM model and a write-back scoreboard.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid, ex_wreg, ex_mem_rd, ex_mem_wr;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_mem_addr, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr, stall_req, wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  logic        bd_we = 1'b0;
  logic [9:0]  bd_a = '0;
  logic [7:0]  bd_d = '0;
  logic [7:0]  ram [1024];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;
  wb_t sb[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_mem_rd    (ex_mem_rd),
    .ex_mem_wr    (ex_mem_wr),
    .ex_funct3    (ex_funct3),
    .ex_mem_addr  (ex_mem_addr),
    .ex_store_data(ex_store_data),
    .mem_din      (mem_din),
    .mem_a        (mem_a),
    .mem_dout     (mem_dout),
    .mem_wr       (mem_wr),
    .stall_req    (stall_req),
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata)
  );

  // Byte RAM, 1-cycle read latency, plus a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) ram[bd_a] <= bd_d;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write-back monitor: every pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    wb_t e;
    if (!rst && wb_we) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(wb_we), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_cycle", 32'(cyc), 32'(e.due));
        chk("wb_waddr", 32'(wb_waddr), 32'(e.a));
        chk("wb_wdata", wb_wdata, e.d);
      end
    end
  end

  function automatic int nb(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_wreg = 1'b0;
  endtask

  task automatic bd(input logic [9:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    next_cycle();
    bd_we = 1'b0;
  endtask

  task automatic do_alu(input logic [4:0] wd, input logic [31:0] d);
    ex_valid = 1'b1; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_funct3 = 3'd0;
    ex_wd = wd; ex_wreg = 1'b1; ex_wdata = d;
    if (wd != 5'd0) sb.push_back('{due: cyc + 1, a: wd, d: d});
    @(negedge clk);
    chk("alu_stall", 32'(stall_req), 32'd0);
    chk("alu_mem_wr", 32'(mem_wr), 32'd0);
    next_cycle();
    idle_in();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] wd, input logic [31:0] expv);
    int n;
    n = nb(f3);
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_funct3 = f3;
    ex_mem_addr = addr; ex_wd = wd; ex_wreg = 1'b1; ex_wdata = 32'hBAD0_BAD0;
    if (wd != 5'd0) sb.push_back('{due: cyc + n + 1, a: wd, d: expv});
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k < n) begin
        chk($sformatf("ld_a%0d", k), mem_a, addr + 32'(k));
        chk($sformatf("ld_stall%0d", k), 32'(stall_req), 32'd1);
      end else begin
        chk("ld_stall_final", 32'(stall_req), 32'd0);
      end
      chk("ld_mem_wr", 32'(mem_wr), 32'd0);
      next_cycle();
    end
    idle_in();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    int n;
    n = nb(f3);
    ex_valid = 1'b1; ex_mem_rd = 1'b0; ex_mem_wr = 1'b1; ex_funct3 = f3;
    ex_mem_addr = addr; ex_store_data = d; ex_wd = 5'd3; ex_wreg = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("st_wr%0d", k), 32'(mem_wr), 32'd1);
      chk($sformatf("st_a%0d", k), mem_a, addr + 32'(k));
      chk($sformatf("st_dout%0d", k), 32'(mem_dout), 32'(d[8*k +: 8]));
      chk($sformatf("st_stall%0d", k), 32'(stall_req), (k < n - 1) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle_in();
    @(negedge clk);
    chk("st_wb_we", 32'(wb_we), 32'd0);
    chk("st_idle_wr", 32'(mem_wr), 32'd0);
    next_cycle();
  endtask

  task automatic do_illegal(input logic rd, input logic [2:0] f3);
    ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = !rd; ex_funct3 = f3;
    ex_mem_addr = 32'h40; ex_store_data = 32'h11; ex_wd = 5'd4; ex_wreg = 1'b1;
    @(negedge clk);
    chk("ill_mem_wr", 32'(mem_wr), 32'd0);
    chk("ill_stall", 32'(stall_req), 32'd0);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("ill_wb_we", 32'(wb_we), 32'd0);
    next_cycle();
  endtask

  initial begin
    idle_in();
    ex_wd = '0; ex_wdata = '0; ex_funct3 = '0; ex_mem_addr = '0; ex_store_data = '0;
    rst = 1'b1;
    next_cycle();
    bd(10'h100, 8'h78); bd(10'h101, 8'h56); bd(10'h102, 8'h34); bd(10'h103, 8'h12);
    bd(10'h007, 8'h80); bd(10'h009, 8'h01); bd(10'h00A, 8'h80);

    ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_funct3 = 3'b010; ex_mem_addr = 32'h55;
    @(negedge clk);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_waddr", 32'(wb_waddr), 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    next_cycle();
    idle_in();
    rst = 1'b0;
    next_cycle();

    do_alu(5'd5, 32'h0000_1234);
    do_load(3'b010, 32'h100, 5'd6, 32'h1234_5678);
    do_load(3'b000, 32'h7, 5'd7, 32'hFFFF_FF80);
    do_load(3'b100, 32'h7, 5'd8, 32'h0000_0080);
    do_load(3'b001, 32'h9, 5'd10, 32'hFFFF_8001);
    do_load(3'b101, 32'h9, 5'd15, 32'h0000_8001);

    do_store(3'b010, 32'h200, 32'hDEAD_BEEF);
    do_load(3'b010, 32'h200, 5'd11, 32'hDEAD_BEEF);
    do_store(3'b000, 32'h300, 32'h1234_56A5);
    do_load(3'b100, 32'h300, 5'd12, 32'h0000_00A5);
    do_store(3'b001, 32'h205, 32'h0000_CAFE);
    do_load(3'b001, 32'h205, 5'd16, 32'hFFFF_CAFE);

    do_load(3'b010, 32'h100, 5'd0, 32'h0);
    do_load(3'b010, 32'h100, 5'd13, 32'h1234_5678);
    do_alu(5'd14, 32'h0000_ABCD);

    do_illegal(1'b1, 3'b011);
    do_illegal(1'b0, 3'b100);

    // Reset during cycle 2 of a word load.
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_funct3 = 3'b010;
    ex_mem_addr = 32'h100; ex_wd = 5'd9; ex_wreg = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("prerst_stall", 32'(stall_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stall_req), 32'd0);
    chk("arst_mem_a", mem_a, 32'd0);
    chk("arst_mem_wr", 32'(mem_wr), 32'd0);
    chk("arst_wb_waddr", 32'(wb_waddr), 32'd0);
    chk("arst_wb_wdata", wb_wdata, 32'd0);
    idle_in();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_wb_we%0d", i), 32'(wb_we), 32'd0);
      next_cycle();
    end
    do_alu(5'd5, 32'h0000_0777);

    for (int i = 0; i < 3; i++) next_cycle();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
